// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: buffers execute-stage results and retires them to the
// 8x16 register file one write per cycle. It also forwards the youngest pending
// value for operand reads that hit a result not yet written.
module reg_writeback_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] q_rega,
  input  logic [ADDR_W-1:0] q_regb,
  output logic              fwd_a_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_b_data,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] ent_reg   [DEPTH];
  logic [DATA_W-1:0] ent_data  [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic push, pop, not_empty;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign wr_en     = not_empty && !wb_hold;
  assign pop       = wr_en;
  assign wr_reg    = not_empty ? ent_reg[head_q]  : '0;
  assign wr_data   = not_empty ? ent_data[head_q] : '0;
  assign count     = count_q;

  // Queue state: push at tail, pop at head on the regfile's capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ent_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_reg[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      // Push and pop never target the same slot: a push is refused when full,
      // and an empty queue does not pop, so both valid-bit updates are safe.
      if (pop) begin
        ent_valid[head_q] <= 1'b0;
        head_q            <= head_q + PTR_W'(1);
      end
      if (push) begin
        ent_reg[tail_q]   <= in_reg;
        ent_data[tail_q]  <= in_data;
        ent_valid[tail_q] <= 1'b1;
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (push && !pop)
        count_q <= count_q + CNT_W'(1);
      else if (pop && !push)
        count_q <= count_q - CNT_W'(1);
    end
  end

  logic [PTR_W-1:0] scan_idx;

  // Forwarding: walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    scan_idx   = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (ent_valid[scan_idx] && ent_reg[scan_idx] == q_rega) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = ent_data[scan_idx];
      end
      if (ent_valid[scan_idx] && ent_reg[scan_idx] == q_regb) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = ent_data[scan_idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a scoreboard of pending writes.
module tb_reg_writeback_queue;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_reg = '0;
  logic [15:0] in_data = '0;
  logic        wb_hold = 1'b0;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [15:0] wr_data;
  logic [2:0]  q_rega = '0;
  logic [2:0]  q_regb = '0;
  logic        fwd_a_hit, fwd_b_hit;
  logic [15:0] fwd_a_data, fwd_b_data;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  ent_t sb[$];

  reg_writeback_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_hold(wb_hold), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .q_rega(q_rega), .q_regb(q_regb),
    .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
    .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending value for a register index, from the scoreboard.
  task automatic model_fwd(input logic [2:0] idx, output logic hit, output logic [15:0] data);
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].r == idx) begin
        hit  = 1'b1;
        data = sb[i].d;
      end
  endtask

  // Check all outputs against the model mid-cycle, then advance one clock.
  task automatic cycle();
    logic exp_en, accept, ha, hb;
    logic [15:0] da, db;
    #1;
    exp_en = (sb.size() != 0) && !wb_hold;
    accept = in_valid && (sb.size() != 4);
    chk("in_ready", in_ready, sb.size() != 4);
    chk("count", count, sb.size());
    chk("wr_en", wr_en, exp_en);
    if (sb.size() != 0) begin
      chk("wr_reg", wr_reg, sb[0].r);
      chk("wr_data", wr_data, sb[0].d);
    end else begin
      chk("wr_reg_idle", wr_reg, 0);
      chk("wr_data_idle", wr_data, 0);
    end
    model_fwd(q_rega, ha, da);
    model_fwd(q_regb, hb, db);
    chk("fwd_a_hit", fwd_a_hit, ha);
    chk("fwd_a_data", fwd_a_data, da);
    chk("fwd_b_hit", fwd_b_hit, hb);
    chk("fwd_b_data", fwd_b_data, db);
    @(posedge clk);
    if (exp_en) void'(sb.pop_front());
    if (accept) sb.push_back('{r: in_reg, d: in_data});
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] r, input logic [15:0] d);
    in_valid = v;
    in_reg   = r;
    in_data  = d;
  endtask

  initial begin
    // Outputs during reset
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fwd_a", fwd_a_hit, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single result, one-cycle latency to the write port
    drive(1, 3'd2, 16'h1234);
    cycle();
    drive(0, 0, 0);
    chk("lat_wr_en", wr_en, 1);
    chk("lat_wr_reg", wr_reg, 2);
    cycle();
    cycle();

    // Fill under hold, refused fifth push, then in-order drain
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 3'(i), 16'(i * 'h11));
      cycle();
    end
    drive(1, 3'd7, 16'h7777);
    cycle();
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    drive(0, 0, 0);
    cycle();
    wb_hold = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // Duplicate destination: youngest value is forwarded
    wb_hold = 1'b1;
    q_rega = 3'd5;
    q_regb = 3'd6;
    drive(1, 3'd5, 16'hAAAA);
    cycle();
    drive(1, 3'd5, 16'hBBBB);
    cycle();
    drive(0, 0, 0);
    #1;
    chk("dup_a_hit", fwd_a_hit, 1);
    chk("dup_a_data", fwd_a_data, 16'hBBBB);
    chk("dup_b_hit", fwd_b_hit, 0);
    chk("dup_b_data", fwd_b_data, 0);
    // Head entry still forwards while it is being written
    wb_hold = 1'b0;
    q_regb = 3'd5;
    cycle();
    cycle();
    cycle();

    // Streaming: push every cycle, wraps pointers several times
    q_rega = 3'd0;
    q_regb = 3'd3;
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'(i), 16'(16'h0100 + i));
      cycle();
      chk("stream_cnt_le1", count <= 1, 1);
    end
    drive(0, 0, 0);
    cycle();
    cycle();

    // Full queue, reset asserted mid-drain
    wb_hold = 1'b1;
    q_rega = 3'd1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i), 16'(16'hC000 + i));
      cycle();
    end
    drive(0, 0, 0);
    wb_hold = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_wr_en", wr_en, 0);
    chk("arst_count", count, 0);
    chk("arst_fwd_a", fwd_a_hit, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();

    // Full with pop and push together: push refused, accepted next cycle
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(4 + i), 16'(16'hD000 + i));
      cycle();
    end
    wb_hold = 1'b0;
    drive(1, 3'd0, 16'hE0E0);
    cycle();
    chk("pp_count3", count, 3);
    wb_hold = 1'b1;
    cycle();
    chk("pp_count4", count, 4);
    drive(0, 0, 0);
    wb_hold = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
